sc_stage_scheduler: RTL and testbench
=====================================

# sc_stage_scheduler

Top-level schedule sequencer for the semi-parallel SC polar decoder (N = 2^n, P = 2^p processing elements). It walks the SC decoding tree bit by bit and issues one stage/exe_index pair per cycle to the read port controller, LLR memory and PE array. It also selects f or g per stage and holds a leaf-decision handshake with the bit-decision/partial-sum unit. It replaces the testbench-driven stage/exe sequencing used so far.

## Interface
- n, default 3: log2 code length; n ≥ 2.
- p, default 1: log2 PE count; 0 ≤ p ≤ n-2.
- PIPE_LAT, default 3: idle cycles after a stage's last issue before the next stage issues; covers read, PE and write-back latency; 0 is legal.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins decoding a codeword; ignored unless IDLE.
- leaf_ack  in  1  decision for bit_index is made and partial sums are updated; ignored unless leaf_req=1.
- en  out  1  issue strobe to the read port controller and PE array.
- stage_index  out  $clog2(n)  stage being computed; n-1 is the channel side.
- exe_index  out  n-p  PE-group index within the stage.
- op_g  out  1  1 = g function, 0 = f function; valid while en=1.
- bit_index  out  n  current leaf bit.
- leaf_req  out  1  stage 0 result is written; held high until leaf_ack.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the ack for bit N-1.

## Operation
- States: IDLE, ISSUE, WAIT, LEAF.
- IDLE + start → ISSUE, bit_index=0, stage=n-1, op_g=0, exe=0.
- ISSUE: en=1 for each cycle. Stage s issues C(s) cycles, where C(s) = 2^(s-p) if s ≥ p, else 1. exe_index runs 0..C(s)-1. After the last issue, go to WAIT, or go straight to the next step if PIPE_LAT=0.
- WAIT: en=0 for PIPE_LAT cycles, counted by a down-counter. Then, if stage > 0: stage-1, op_g=0, exe=0, → ISSUE. If stage = 0: → LEAF.
- LEAF: leaf_req=1.
  - leaf_ack with bit_index < N-1: bit_index+1, stage = ctz(bit_index+1), op_g=1, → ISSUE.
  - leaf_ack with bit_index = N-1: done=1, busy=0, → IDLE.
- Bit 0 runs all f from stage n-1. Every later bit runs one g stage, then f stages down to 0.
- exe_index and bit_index never wrap mid-stage. bit_index resets to 0 only on start.
- start while busy is ignored. leaf_ack outside LEAF is ignored. start in the same cycle as a done pulse is honoured, because the FSM is already IDLE.

## Timing
- All outputs are registered. Reset value of every output is 0, state is IDLE, and counters are 0.
- start sampled at cycle t gives busy=1, en=1, stage=n-1 at t+1.
- leaf_ack sampled at cycle t gives leaf_req=0 at t+1 and either en=1 or done=1 at t+1.
- Reset mid-decode aborts immediately. The first start after reset begins a fresh codeword.

## Configuration
- SC_SCHED_PERF_CNT_EN defined:
  - Adds output cycle_count [31:0].
  - It is cleared at start and increments every busy cycle.
  - It freezes at done, which makes it readable after the decode.
  - Saturates at 2^32-1.
- SC_SCHED_PERF_CNT_EN undefined: the port and counter are absent.

## Structure
- Package sc_sched_pkg holds:
  - the state enum;
  - the C(s) cycle-count function;
  - the localparams N, EXE_W = n-p and STG_W = $clog2(n).
- Sub-module sc_ctz: combinational trailing-zero count of bit_index+1, width n, saturating output at n-1.

## Test plan
- n=3, p=1, PIPE_LAT=2, start at cycle 0, leaf_ack tied high:
  - en high at cycles 1–2 (stage 2, exe 0,1), cycle 5 (stage 1) and cycle 8 (stage 0);
  - leaf_req rises at cycle 11.
- Same config, bit 1: after the ack, a single g issue at stage 0, then leaf_req after 2 WAIT cycles. For bit 4: g at stage 2 (2 cycles), then f at stages 1 and 0.
- Full codeword, n=3: exactly 8 leaf_req handshakes, bit_index 0..7 in order, done pulses once, busy=0 on the following cycle.
- leaf_ack withheld for 5 cycles: leaf_req, bit_index and stage are held and en stays 0. A start pulse during this window has no effect.
- PIPE_LAT=0, n=4, p=0: stages issue back-to-back with no en gap. Bit 0 takes 8+4+2+1 = 15 consecutive en cycles.
- rst_n asserted mid-ISSUE: all outputs are 0 asynchronously. A subsequent start restarts at bit 0, stage n-1. With SC_SCHED_PERF_CNT_EN, cycle_count equals the busy duration of an uninterrupted decode.

Source files
------------

// File: rtl/sc_stage_scheduler_pkg.sv
// Shared types and geometry helpers for the SC polar decoder schedule sequencer.
// N/EXE_W/STG_W describe the default build (n=3, p=1).
package sc_sched_pkg;

  localparam int unsigned N     = 8;
  localparam int unsigned EXE_W = 2;
  localparam int unsigned STG_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    LEAF  = 2'd3
  } sc_state_e;

  // Issue cycles for stage s with 2^p PEs: a stage narrower than the array still costs one cycle.
  function automatic int unsigned stage_cycles(input int unsigned s, input int unsigned p);
    return (s >= p) ? (32'd1 << (s - p)) : 32'd1;
  endfunction

endpackage

// File: rtl/sc_stage_scheduler_if.sv
// Handshake/issue bundle between the schedule sequencer and its controller.
// SC_SCHED_PERF_CNT_EN adds the cycle_count readback.
interface sc_stage_scheduler_if #(
  parameter int unsigned n = 3,
  parameter int unsigned p = 1
);
  localparam int unsigned EW = n - p;
  localparam int unsigned SW = $clog2(n);

  logic          start;
  logic          leaf_ack;
  logic          en;
  logic [SW-1:0] stage_index;
  logic [EW-1:0] exe_index;
  logic          op_g;
  logic [n-1:0]  bit_index;
  logic          leaf_req;
  logic          busy;
  logic          done;
`ifdef SC_SCHED_PERF_CNT_EN
  logic [31:0]   cycle_count;
`endif

  modport master (
    output start, leaf_ack,
    input  en, stage_index, exe_index, op_g, bit_index, leaf_req, busy, done
`ifdef SC_SCHED_PERF_CNT_EN
    , input cycle_count
`endif
  );

  modport slave (
    input  start, leaf_ack,
    output en, stage_index, exe_index, op_g, bit_index, leaf_req, busy, done
`ifdef SC_SCHED_PERF_CNT_EN
    , output cycle_count
`endif
  );

endinterface

// File: rtl/sc_stage_scheduler_ctz.sv
// Trailing-zero count of bit_index+1: the g stage where the next leaf's subtree starts.
// All-ones input wraps to zero and saturates at n-1.
module sc_ctz
  import sc_sched_pkg::*;
#(
  parameter int unsigned n  = $clog2(N),
  parameter int unsigned SW = STG_W
) (
  input  logic [n-1:0]  bit_index,
  output logic [SW-1:0] ctz
);

  logic [n-1:0] inc_s;

  // Scan from the top so the lowest set bit is the last one to win.
  always_comb begin
    inc_s = bit_index + {{(n-1){1'b0}}, 1'b1};
    ctz   = SW'(n - 1);
    for (int i = n - 1; i >= 0; i--) begin
      ctz = inc_s[i] ? SW'(i) : ctz;
    end
  end

endmodule

// File: rtl/sc_stage_scheduler.sv
// SC decoding tree walker: issues one stage/exe_index per cycle and handshakes each leaf decision.
// SC_SCHED_PERF_CNT_EN adds a saturating busy-cycle counter on the interface.
module sc_stage_scheduler
  import sc_sched_pkg::*;
#(
  parameter int unsigned n        = $clog2(N),
  parameter int unsigned p        = $clog2(N) - EXE_W,
  parameter int unsigned PIPE_LAT = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  sc_stage_scheduler_if.slave bus
);

  localparam int unsigned EW = n - p;
  localparam int unsigned SW = $clog2(n);
  localparam int unsigned CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  sc_state_e     state_r, state_s, adv_state_s;
  logic [SW-1:0] stage_r, stage_s, adv_stage_s, ctz_s;
  logic [EW-1:0] exe_r, exe_s;
  logic [n-1:0]  bit_r, bit_s;
  logic [CW-1:0] wcnt_r, wcnt_s;
  logic          op_g_r, op_g_s;
  logic          en_r, leaf_req_r, busy_r, done_r, done_s;
  logic          last_issue_s;

  sc_ctz #(.n(n), .SW(SW)) u_ctz (
    .bit_index (bit_r),
    .ctz       (ctz_s)
  );

  assign last_issue_s = (32'(exe_r) == stage_cycles(32'(stage_r), p) - 32'd1);

  // Where the walk goes once the current stage has drained: one stage down, or the leaf.
  always_comb begin
    if (stage_r != '0) begin
      adv_state_s = ISSUE;
      adv_stage_s = stage_r - SW'(1'b1);
    end else begin
      adv_state_s = LEAF;
      adv_stage_s = stage_r;
    end
  end

  // Next-state and next-output logic of the tree walk.
  always_comb begin
    state_s = state_r;
    stage_s = stage_r;
    exe_s   = exe_r;
    bit_s   = bit_r;
    op_g_s  = op_g_r;
    wcnt_s  = wcnt_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s = ISSUE;
          stage_s = SW'(n - 1);
          exe_s   = '0;
          op_g_s  = 1'b0;
          bit_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (!last_issue_s) begin
          exe_s = exe_r + EW'(1'b1);
        end else if (PIPE_LAT != 0) begin
          state_s = WAIT;
          wcnt_s  = CW'(PIPE_LAT - 1);
        end else begin
          state_s = adv_state_s;
          stage_s = adv_stage_s;
          exe_s   = '0;
          op_g_s  = 1'b0;
        end
      end
      WAIT: begin
        if (wcnt_r != '0) begin
          wcnt_s = wcnt_r - CW'(1'b1);
        end else begin
          state_s = adv_state_s;
          stage_s = adv_stage_s;
          exe_s   = '0;
          op_g_s  = 1'b0;
        end
      end
      LEAF: begin
        if (!bus.leaf_ack) begin
          state_s = LEAF;
        end else if (bit_r == {n{1'b1}}) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          // Next leaf re-enters the tree with a g at the subtree root, then f down to 0.
          state_s = ISSUE;
          bit_s   = bit_r + {{(n-1){1'b0}}, 1'b1};
          stage_s = ctz_s;
          exe_s   = '0;
          op_g_s  = 1'b1;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      stage_r    <= '0;
      exe_r      <= '0;
      bit_r      <= '0;
      op_g_r     <= 1'b0;
      wcnt_r     <= '0;
      en_r       <= 1'b0;
      leaf_req_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      stage_r    <= stage_s;
      exe_r      <= exe_s;
      bit_r      <= bit_s;
      op_g_r     <= op_g_s;
      wcnt_r     <= wcnt_s;
      en_r       <= (state_s == ISSUE);
      leaf_req_r <= (state_s == LEAF);
      busy_r     <= (state_s != IDLE);
      done_r     <= done_s;
    end
  end

  assign bus.en          = en_r;
  assign bus.stage_index = stage_r;
  assign bus.exe_index   = exe_r;
  assign bus.op_g        = op_g_r;
  assign bus.bit_index   = bit_r;
  assign bus.leaf_req    = leaf_req_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;

`ifdef SC_SCHED_PERF_CNT_EN
  logic [31:0] cyc_r;

  // Busy-cycle counter: cleared on an accepted start, frozen once busy drops, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_r <= 32'd0;
    end else if (state_r == IDLE && bus.start) begin
      cyc_r <= 32'd0;
    end else if (busy_r && cyc_r != 32'hFFFF_FFFF) begin
      cyc_r <= cyc_r + 32'd1;
    end else begin
      cyc_r <= cyc_r;
    end
  end

  assign bus.cycle_count = cyc_r;
`endif

endmodule

// File: tb/tb_sc_stage_scheduler.sv
// Directed bench for sc_stage_scheduler: n=3/p=1/PIPE_LAT=2 and n=4/p=0/PIPE_LAT=0 instances.
// Checks cycle_count when built with SC_SCHED_PERF_CNT_EN.
module tb_sc_stage_scheduler;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sc_stage_scheduler_if #(.n(3), .p(1)) bus_a ();
  sc_stage_scheduler_if #(.n(4), .p(0)) bus_b ();

  sc_stage_scheduler #(.n(3), .p(1), .PIPE_LAT(2)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  sc_stage_scheduler #(.n(4), .p(0), .PIPE_LAT(0)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  typedef struct {
    logic       start;
    logic       ack;
    logic       en;
    logic [1:0] stg;
    logic [1:0] exe;
    logic       g;
    logic [2:0] bi;
    logic       lr;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic en, input int stg, input int exe, input logic g, input int bi, input logic lr);
    vec_t v;
    v.start = 1'b0;  v.ack = 1'b1;   v.en = en;     v.stg = 2'(stg);
    v.exe   = 2'(exe); v.g = g;      v.bi = 3'(bi); v.lr = lr;
    v.busy  = 1'b1;  v.done = 1'b0;
    tbl.push_back(v);
  endtask

  task automatic iss(input int stg, input int exe, input logic g, input int bi);
    add(1'b1, stg, exe, g, bi, 1'b0);
  endtask

  // PIPE_LAT=2 idle cycles after a stage
  task automatic wt(input int stg, input int bi);
    add(1'b0, stg, 0, 1'b0, bi, 1'b0);
    add(1'b0, stg, 0, 1'b0, bi, 1'b0);
  endtask

  task automatic lf(input int bi);
    add(1'b0, 0, 0, 1'b0, bi, 1'b1);
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, "_en"},    32'(bus_a.en),          32'd0);
    chk({tag, "_stage"}, 32'(bus_a.stage_index), 32'd0);
    chk({tag, "_exe"},   32'(bus_a.exe_index),   32'd0);
    chk({tag, "_opg"},   32'(bus_a.op_g),        32'd0);
    chk({tag, "_bit"},   32'(bus_a.bit_index),   32'd0);
    chk({tag, "_req"},   32'(bus_a.leaf_req),    32'd0);
    chk({tag, "_busy"},  32'(bus_a.busy),        32'd0);
    chk({tag, "_done"},  32'(bus_a.done),        32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  exp_bit;
    int  h;
    int  dn;
    bit  seen;
    bit  fin;

    bus_a.start = 1'b0; bus_a.leaf_ack = 1'b0;
    bus_b.start = 1'b0; bus_b.leaf_ack = 1'b0;

    // Bits 0..4 of a codeword with leaf_ack tied high
    iss(2, 0, 1'b0, 0); iss(2, 1, 1'b0, 0); wt(2, 0);
    iss(1, 0, 1'b0, 0); wt(1, 0);
    iss(0, 0, 1'b0, 0); wt(0, 0); lf(0);
    iss(0, 0, 1'b1, 1); wt(0, 1); lf(1);
    iss(1, 0, 1'b1, 2); wt(1, 2); iss(0, 0, 1'b0, 2); wt(0, 2); lf(2);
    iss(0, 0, 1'b1, 3); wt(0, 3); lf(3);
    iss(2, 0, 1'b1, 4); iss(2, 1, 1'b1, 4); wt(2, 4);
    iss(1, 0, 1'b0, 4); wt(1, 4);
    iss(0, 0, 1'b0, 4); wt(0, 4); lf(4);
    tbl[0].start = 1'b1;

    #12;
    chk_a_zero("reset");
    chk("reset_b_busy", 32'(bus_b.busy), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < tbl.size(); i++) begin
      bus_a.start    = tbl[i].start;
      bus_a.leaf_ack = tbl[i].ack;
      step();
      bus_a.start = 1'b0;
      chk("tbl_en",    32'(bus_a.en),          32'(tbl[i].en));
      chk("tbl_stage", 32'(bus_a.stage_index), 32'(tbl[i].stg));
      chk("tbl_bit",   32'(bus_a.bit_index),   32'(tbl[i].bi));
      chk("tbl_req",   32'(bus_a.leaf_req),    32'(tbl[i].lr));
      chk("tbl_busy",  32'(bus_a.busy),        32'(tbl[i].busy));
      chk("tbl_done",  32'(bus_a.done),        32'(tbl[i].done));
      if (tbl[i].en) begin
        chk("tbl_exe", 32'(bus_a.exe_index), 32'(tbl[i].exe));
        chk("tbl_opg", 32'(bus_a.op_g),      32'(tbl[i].g));
      end
    end

    // Withhold the ack on bit 4 and pulse start meanwhile
    bus_a.leaf_ack = 1'b0;
    bus_a.start    = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      bus_a.start = 1'b0;
      chk("hold_req",   32'(bus_a.leaf_req),    32'd1);
      chk("hold_bit",   32'(bus_a.bit_index),   32'd4);
      chk("hold_stage", 32'(bus_a.stage_index), 32'd0);
      chk("hold_en",    32'(bus_a.en),          32'd0);
      chk("hold_busy",  32'(bus_a.busy),        32'd1);
    end

    bus_a.leaf_ack = 1'b1;
    exp_bit = 5;
    seen    = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      step();
      if (bus_a.done) begin
        seen = 1'b1;
      end else if (bus_a.leaf_req) begin
        chk("run1_bit_order", 32'(bus_a.bit_index), 32'(exp_bit));
        exp_bit++;
      end
    end
    chk("run1_done_seen", 32'(seen), 32'd1);
    chk("run1_last_bit", 32'(exp_bit), 32'd8);
    chk("run1_done_busy", 32'(bus_a.busy), 32'd0);

    // Start in the done cycle is honoured
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    chk("restart_busy",  32'(bus_a.busy),        32'd1);
    chk("restart_en",    32'(bus_a.en),          32'd1);
    chk("restart_stage", 32'(bus_a.stage_index), 32'd2);
    chk("restart_bit",   32'(bus_a.bit_index),   32'd0);
    chk("restart_exe",   32'(bus_a.exe_index),   32'd0);
    chk("restart_done",  32'(bus_a.done),        32'd0);

    h   = 0;
    dn  = 0;
    fin = 1'b0;
    for (int k = 0; k < 200 && !fin; k++) begin
      step();
      if (bus_a.leaf_req) begin
        chk("run2_bit_order", 32'(bus_a.bit_index), 32'(h));
        h++;
      end
      if (bus_a.done) begin
        dn++;
        chk("run2_done_busy", 32'(bus_a.busy), 32'd0);
`ifdef SC_SCHED_PERF_CNT_EN
        chk("cycle_count", bus_a.cycle_count, 32'd52);
`endif
        step();
        chk("run2_post_busy", 32'(bus_a.busy), 32'd0);
        chk("run2_post_done", 32'(bus_a.done), 32'd0);
        fin = 1'b1;
      end
    end
    chk("run2_handshakes", 32'(h), 32'd8);
    chk("run2_done_count", 32'(dn), 32'd1);

    // Asynchronous reset in the middle of an issue burst
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    step();
    chk("pre_rst_en", 32'(bus_a.en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_a_zero("async_rst");
`ifdef SC_SCHED_PERF_CNT_EN
    chk("rst_cycle_count", bus_a.cycle_count, 32'd0);
`endif
    step();
    rst_n = 1'b1;
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    chk("post_rst_en",    32'(bus_a.en),          32'd1);
    chk("post_rst_stage", 32'(bus_a.stage_index), 32'd2);
    chk("post_rst_bit",   32'(bus_a.bit_index),   32'd0);
    chk("post_rst_busy",  32'(bus_a.busy),        32'd1);

    // PIPE_LAT=0, n=4, p=0: bit 0 is 15 back-to-back issues
    bus_b.start = 1'b1;
    step();
    bus_b.start = 1'b0;
    for (int s = 3; s >= 0; s--) begin
      for (int e = 0; e < (1 << s); e++) begin
        chk("b_en",    32'(bus_b.en),          32'd1);
        chk("b_stage", 32'(bus_b.stage_index), 32'(s));
        chk("b_exe",   32'(bus_b.exe_index),   32'(e));
        chk("b_opg",   32'(bus_b.op_g),        32'd0);
        step();
      end
    end
    chk("b_leaf_en",  32'(bus_b.en),       32'd0);
    chk("b_leaf_req", 32'(bus_b.leaf_req), 32'd1);
    bus_b.leaf_ack = 1'b1;
    step();
    bus_b.leaf_ack = 1'b0;
    chk("b_ack_req",   32'(bus_b.leaf_req),    32'd0);
    chk("b_ack_en",    32'(bus_b.en),          32'd1);
    chk("b_ack_stage", 32'(bus_b.stage_index), 32'd0);
    chk("b_ack_opg",   32'(bus_b.op_g),        32'd1);
    chk("b_ack_bit",   32'(bus_b.bit_index),   32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
